cassette_rec: RTL and testbench
===============================

# cassette_rec

Tape recorder for the Electron cassette path, the write-side counterpart of the cassette player. It samples the ULA cassette-out signal and decodes the 1200 Hz / 2400 Hz FSK tone into raw bits. Bits are packed into bytes, bit 0 first, and each byte is written sequentially into SDRAM from address 0. The resulting image replays bit-exact through the existing player: bit 0 of each stored byte is played first, 1200 Hz cycle = 0, two 2400 Hz cycles = 1.

## Interface
Parameters:
- SHORT_MAX, 5000: half-cycle length in clk cycles. Below this the half-cycle is short (2400 Hz, nominal 3333); at or above it is long (1200 Hz, nominal 6666).
- TIMEOUT, 20000: clk cycles without an edge before the carrier is declared lost.

Ports (clock and reset first):
- clk  in  1  system clock, 16 MHz.
- reset  in  1  synchronous, active-high.
- en  in  1  record enable, level.
- cas_in  in  1  asynchronous FSK tape signal.
- sdram_addr  out  25  write address.
- sdram_din  out  8  write data.
- sdram_wr  out  1  write request, held until acknowledged.
- sdram_ack  in  1  one-cycle write acknowledge.
- tape_end  out  25  bytes recorded so far; equals the next free address.
- overrun  out  1  sticky: a byte was lost because the previous write was still pending.
- full  out  1  sticky: the address space is exhausted.
- status  out  3  current FSM state encoding.

## Operation
Input path:
- cas_in passes through a 2-flop synchronizer and then an edge detector (both edges).
- A 16-bit interval counter resets on every edge and saturates at TIMEOUT.

Bit decoder (classifies each completed half-cycle):
- Long half-cycle: short_cnt clears, long_cnt increments. At long_cnt==2, emit bit 0 and clear long_cnt.
- Short half-cycle: long_cnt clears, short_cnt increments. At short_cnt==4, emit bit 1 and clear short_cnt.
- Mixed patterns therefore resynchronize without emitting a bit.
- The first edge after arming only starts interval timing; it is not classified.

Byte packer:
- An 8-bit shift register fills LSB first, with a 3-bit count.
- On the 8th bit the byte is copied into the write holding register and the count clears.

FSM states:
- IDLE(0): outputs quiescent.
- ARM(1): waiting for the first edge.
- RUN(2): decoding.
- WRITE(3): sdram_wr asserted.
- FLUSH(4): pad the partial byte with 1s and write it.
- DONE(5).

FSM transitions:
- Rising en in any state: sdram_addr, tape_end and the decoder clear; overrun and full clear; go to ARM.
- ARM: first edge -> RUN.
- RUN: byte complete -> WRITE, with decoding continuing in parallel. A byte completing while in WRITE sets overrun and is dropped.
- WRITE: sdram_ack -> sdram_addr and tape_end increment, then return to RUN, or to FLUSH/DONE if one is pending.
- Interval reaching TIMEOUT in RUN: if count>0, FLUSH then ARM; otherwise ARM directly. sdram_addr is kept.
- Falling en: if count>0, FLUSH then DONE; otherwise DONE. DONE -> IDLE next cycle.
- A write acked at address 25'h1FFFFFF sets full and goes to DONE. No wrap.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - Shift register, counters, long_cnt and short_cnt all 0.
- Edge latency: cas_in transition -> edge pulse 3 clk later.
- Bit latency: edge pulse -> emitted bit 1 clk later. Byte complete -> sdram_wr high the next clk.
- Write handshake:
  - sdram_addr and sdram_din are stable while sdram_wr is high.
  - sdram_wr drops and the address increments on the clk after sdram_ack is sampled.
  - sdram_ack while sdram_wr is low is ignored.
- Simultaneous events:
  - Rising en beats everything else.
  - Falling en during WRITE: the write completes, then FLUSH.
  - TIMEOUT and falling en in the same cycle: take the falling-en path.
- Reset mid-write drops sdram_wr immediately; a pending ack is ignored.

## Structure
- Shared package cassette_pkg holds:
  - The state encodings, so status decodes identically for player and recorder.
  - Nominal half-cycle constants (3333, 6666).
  - SDRAM address width 25.
- Sub-module fsk_bit_decoder contains the synchronizer, edge detect, interval counter and long/short counters. Its outputs are bit_valid, bit_val and carrier_lost.
- The top level holds the packer, FSM and SDRAM handshake.

## Test plan
- Byte decode: en rising, then 8 bits 1,0,1,0,0,0,0,0 (1 = 4×3333-cycle half-cycles, 0 = 2×6666-cycle half-cycles) -> one write of sdram_din=8'h05 at addr 0, tape_end=1.
- Multi-byte order: bytes 8'hAA then 8'h3C with ack after 5 cycles -> writes at addr 0 and 1, then tape_end=2.
- Flush on carrier loss: 3 bits 0,1,1 then silence >20000 cycles -> flush write of 8'hFE, then ARM with sdram_addr=1.
- Glitch resync: 3 short half-cycles then 2 long -> exactly one 0 bit, no 1 bit.
- Overrun and full:
  - Hold sdram_ack low for 2 byte-times -> overrun=1, exactly one write pending.
  - Preset to 25'h1FFFFFF via a back-door force, then ack -> full=1, state DONE.
- Reset and re-arm: reset asserted with sdram_wr high -> sdram_wr=0 the next cycle, all outputs 0. A later en rise resets addr to 0.

Source files
------------

// File: rtl/cassette_pkg.sv
// Shared definitions for the cassette player/recorder pair: FSM state encodings,
// nominal FSK half-cycle lengths, SDRAM address width and the partial-byte pad helper.
package cassette_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_WRITE = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int HALF_SHORT_NOM = 3333;
    localparam int HALF_LONG_NOM  = 6666;
    localparam int ADDR_W         = 25;
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    // Partial bytes sit in the top cnt bits of the shift register; move them down
    // to bit 0 and fill the unused positions with 1s.
    function automatic logic [7:0] pad_byte(input logic [7:0] shift, input logic [2:0] cnt);
        return (shift >> (4'd8 - {1'b0, cnt})) | (8'hFF << cnt);
    endfunction

endpackage

// File: rtl/fsk_bit_decoder.sv
// Turns the asynchronous FSK tape signal into raw bits: synchronizer, edge detect,
// half-cycle interval timing and long/short run counting.
module fsk_bit_decoder
    import cassette_pkg::*;
#(
    parameter int SHORT_MAX = 5000,
    parameter int TIMEOUT   = 20000
)
(
    input  logic clk,
    input  logic reset,
    input  logic rearm,
    input  logic cas_in,
    output logic edge_pulse,
    output logic bit_valid,
    output logic bit_val,
    output logic carrier_lost
);

    localparam logic [15:0] SHORT_LIM = 16'(SHORT_MAX);
    localparam logic [15:0] TMO_LIM   = 16'(TIMEOUT);

    logic [1:0]  r_sync;
    logic        r_prev;
    logic        r_edge;
    logic [15:0] r_interval;
    logic        r_lost;
    logic [1:0]  r_long_cnt;
    logic [2:0]  r_short_cnt;
    logic        r_first;
    logic        r_bit_valid;
    logic        r_bit_val;

    // Two-flop synchronizer followed by a registered both-edge detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], cas_in};
            r_prev <= r_sync[1];
            r_edge <= r_sync[1] ^ r_prev;
        end
    end

    // Interval since the last edge, parked at the timeout value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_interval <= 16'd0;
            r_lost     <= 1'b0;
        end else begin
            if (r_edge) begin
                r_interval <= 16'd0;
            end else if (r_interval < TMO_LIM) begin
                r_interval <= r_interval + 16'd1;
            end
            r_lost <= ~r_edge && (r_interval >= TMO_LIM - 16'd1);
        end
    end

    // Classify each completed half-cycle; any mix of long and short restarts both runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_long_cnt  <= 2'd0;
            r_short_cnt <= 3'd0;
            r_first     <= 1'b1;
            r_bit_valid <= 1'b0;
            r_bit_val   <= 1'b0;
        end else begin
            r_bit_valid <= 1'b0;
            if (rearm) begin
                r_long_cnt  <= 2'd0;
                r_short_cnt <= 3'd0;
                r_first     <= ~r_edge;
            end else if (r_edge) begin
                if (r_first) begin
                    r_first <= 1'b0;
                end else if (r_interval < SHORT_LIM) begin
                    r_long_cnt <= 2'd0;
                    if (r_short_cnt == 3'd3) begin
                        r_short_cnt <= 3'd0;
                        r_bit_valid <= 1'b1;
                        r_bit_val   <= 1'b1;
                    end else begin
                        r_short_cnt <= r_short_cnt + 3'd1;
                    end
                end else begin
                    r_short_cnt <= 3'd0;
                    if (r_long_cnt == 2'd1) begin
                        r_long_cnt  <= 2'd0;
                        r_bit_valid <= 1'b1;
                        r_bit_val   <= 1'b0;
                    end else begin
                        r_long_cnt <= r_long_cnt + 2'd1;
                    end
                end
            end
        end
    end

    assign edge_pulse   = r_edge;
    assign bit_valid    = r_bit_valid;
    assign bit_val      = r_bit_val;
    assign carrier_lost = r_lost;

endmodule

// File: rtl/cassette_rec.sv
// Cassette recorder top: packs decoded bits LSB first into bytes and streams them
// to SDRAM from address 0 under a write/ack handshake.
module cassette_rec
    import cassette_pkg::*;
#(
    parameter int SHORT_MAX = 5000,
    parameter int TIMEOUT   = 20000
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              cas_in,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [7:0]        sdram_din,
    output logic              sdram_wr,
    input  logic              sdram_ack,
    output logic [ADDR_W-1:0] tape_end,
    output logic              overrun,
    output logic              full,
    output logic [2:0]        status
);

    state_t            r_state, w_state_nxt;
    state_t            r_pend, w_pend_nxt;
    state_t            r_flush_to, w_flush_to_nxt;
    logic              r_en_d;
    logic [7:0]        r_shift;
    logic [2:0]        r_cnt;
    logic [7:0]        r_hold;
    logic [ADDR_W-1:0] r_addr;
    logic              r_overrun;
    logic              r_full;
    logic              r_wr;

    logic w_en_rise, w_en_fall, w_rearm;
    logic w_edge, w_bit_valid, w_bit_val, w_carrier_lost;
    logic w_bit_take, w_byte_done;

    assign w_en_rise   = en & ~r_en_d;
    assign w_en_fall   = ~en & r_en_d;
    assign w_rearm     = w_en_rise || (r_state == ST_IDLE) || (r_state == ST_ARM) || (r_state == ST_DONE);
    // Decoding continues during a plain write so a following byte can still be caught.
    assign w_bit_take  = w_bit_valid && !w_en_rise &&
                         ((r_state == ST_RUN) || ((r_state == ST_WRITE) && (r_pend == ST_RUN)));
    assign w_byte_done = w_bit_take && (r_cnt == 3'd7);

    fsk_bit_decoder #(
        .SHORT_MAX (SHORT_MAX),
        .TIMEOUT   (TIMEOUT)
    ) u_dec (
        .clk          (clk),
        .reset        (reset),
        .rearm        (w_rearm),
        .cas_in       (cas_in),
        .edge_pulse   (w_edge),
        .bit_valid    (w_bit_valid),
        .bit_val      (w_bit_val),
        .carrier_lost (w_carrier_lost)
    );

    // State register plus the post-write and post-flush destinations.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pend     <= ST_RUN;
            r_flush_to <= ST_ARM;
        end else begin
            r_state    <= w_state_nxt;
            r_pend     <= w_pend_nxt;
            r_flush_to <= w_flush_to_nxt;
        end
    end

    // Next-state logic; a rising enable overrides every other event.
    always_comb begin
        w_state_nxt    = r_state;
        w_pend_nxt     = r_pend;
        w_flush_to_nxt = r_flush_to;
        if (w_en_rise) begin
            w_state_nxt = ST_ARM;
            w_pend_nxt  = ST_RUN;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_IDLE;
                ST_ARM: begin
                    if (w_en_fall)   w_state_nxt = ST_DONE;
                    else if (w_edge) w_state_nxt = ST_RUN;
                    else             w_state_nxt = ST_ARM;
                end
                ST_RUN: begin
                    if (w_byte_done) begin
                        w_state_nxt = ST_WRITE;
                        w_pend_nxt  = w_en_fall ? ST_DONE : ST_RUN;
                    end else if (w_en_fall) begin
                        w_state_nxt    = (r_cnt != 3'd0) ? ST_FLUSH : ST_DONE;
                        w_flush_to_nxt = ST_DONE;
                    end else if (w_carrier_lost) begin
                        w_state_nxt    = (r_cnt != 3'd0) ? ST_FLUSH : ST_ARM;
                        w_flush_to_nxt = ST_ARM;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_WRITE: begin
                    if (w_en_fall && (r_pend != ST_DONE)) begin
                        if (r_pend == ST_FLUSH) begin
                            w_flush_to_nxt = ST_DONE;
                        end else if ((r_pend == ST_RUN) && (r_cnt != 3'd0)) begin
                            w_pend_nxt     = ST_FLUSH;
                            w_flush_to_nxt = ST_DONE;
                        end else begin
                            w_pend_nxt = ST_DONE;
                        end
                    end else if (w_carrier_lost && (r_pend == ST_RUN)) begin
                        w_pend_nxt     = (r_cnt != 3'd0) ? ST_FLUSH : ST_ARM;
                        w_flush_to_nxt = ST_ARM;
                    end else begin
                        w_pend_nxt = r_pend;
                    end
                    if (sdram_ack) begin
                        w_state_nxt = (r_addr == ADDR_MAX) ? ST_DONE : w_pend_nxt;
                    end else begin
                        w_state_nxt = ST_WRITE;
                    end
                end
                ST_FLUSH: begin
                    w_state_nxt = ST_WRITE;
                    w_pend_nxt  = w_en_fall ? ST_DONE : r_flush_to;
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Byte packer, write holding register, address and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= 8'd0;
            r_cnt     <= 3'd0;
            r_hold    <= 8'd0;
            r_addr    <= '0;
            r_overrun <= 1'b0;
            r_full    <= 1'b0;
        end else if (w_en_rise) begin
            r_shift   <= 8'd0;
            r_cnt     <= 3'd0;
            r_addr    <= '0;
            r_overrun <= 1'b0;
            r_full    <= 1'b0;
        end else begin
            if (r_state == ST_FLUSH) begin
                r_hold  <= pad_byte(r_shift, r_cnt);
                r_shift <= 8'd0;
                r_cnt   <= 3'd0;
            end else if (w_byte_done) begin
                r_shift <= 8'd0;
                r_cnt   <= 3'd0;
                if (r_state == ST_RUN) r_hold <= {w_bit_val, r_shift[7:1]};
                else                   r_overrun <= 1'b1;
            end else if (w_bit_take) begin
                r_shift <= {w_bit_val, r_shift[7:1]};
                r_cnt   <= r_cnt + 3'd1;
            end
            if ((r_state == ST_WRITE) && sdram_ack) begin
                if (r_addr == ADDR_MAX) r_full <= 1'b1;
                else                    r_addr <= r_addr + 25'd1;
            end
        end
    end

    // Write request and enable history.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr   <= 1'b0;
            r_en_d <= 1'b0;
        end else begin
            r_wr   <= (w_state_nxt == ST_WRITE);
            r_en_d <= en;
        end
    end

    assign sdram_addr = r_addr;
    assign tape_end   = r_addr;
    assign sdram_din  = r_hold;
    assign sdram_wr   = r_wr;
    assign overrun    = r_overrun;
    assign full       = r_full;
    assign status     = r_state;

endmodule

// File: tb/tb_cassette_rec.sv
// Directed-random bench for cassette_rec: drives FSK half-cycles, acks SDRAM writes and
// compares every write against a bit-list packing model.
module tb_cassette_rec;

    localparam int SHORT_MAX = 30;
    localparam int TIMEOUT   = 120;

    logic        clk, reset, en, cas_in, sdram_ack;
    logic [24:0] sdram_addr, tape_end;
    logic [7:0]  sdram_din;
    logic        sdram_wr, overrun, full;
    logic [2:0]  status;

    cassette_rec #(.SHORT_MAX(SHORT_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .cas_in     (cas_in),
        .sdram_addr (sdram_addr),
        .sdram_din  (sdram_din),
        .sdram_wr   (sdram_wr),
        .sdram_ack  (sdram_ack),
        .tape_end   (tape_end),
        .overrun    (overrun),
        .full       (full),
        .status     (status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass = 0;
    int n_total = 0;
    bit ack_hold = 1'b0;
    bit stab_en = 1'b1;
    int ack_delay = 2;
    int unstable = 0;
    logic [24:0] wq_addr[$];
    logic [7:0]  wq_data[$];
    logic [24:0] ea[$];
    logic [7:0]  ed[$];
    bit          mbits[$];
    logic [24:0] exp_addr = 25'd0;

    // SDRAM model: acknowledges after ack_delay low-phase samples and logs each write.
    initial begin : responder
        int wait_cnt;
        logic prev_wr;
        logic [24:0] prev_addr;
        logic [7:0] prev_din;
        wait_cnt = 0;
        prev_wr = 1'b0;
        prev_addr = 25'd0;
        prev_din = 8'd0;
        sdram_ack = 1'b0;
        forever begin
            @(negedge clk);
            sdram_ack = 1'b0;
            if (stab_en && sdram_wr === 1'b1 && prev_wr && (sdram_addr !== prev_addr || sdram_din !== prev_din))
                unstable++;
            prev_wr = (sdram_wr === 1'b1);
            prev_addr = sdram_addr;
            prev_din = sdram_din;
            if (sdram_wr === 1'b1 && !ack_hold) begin
                if (wait_cnt >= ack_delay) begin
                    sdram_ack = 1'b1;
                    wq_addr.push_back(sdram_addr);
                    wq_data.push_back(sdram_din);
                    wait_cnt = 0;
                    prev_wr = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end else if (sdram_wr !== 1'b1) begin
                wait_cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mbits.delete();
        exp_addr = 25'd0;
    endtask

    task automatic model_bit(input bit b);
        logic [7:0] v;
        mbits.push_back(b);
        if (mbits.size() == 8) begin
            v = 8'd0;
            for (int i = 0; i < 8; i++) v[i[2:0]] = mbits[i];
            ea.push_back(exp_addr);
            ed.push_back(v);
            exp_addr = exp_addr + 25'd1;
            mbits.delete();
        end
    endtask

    task automatic model_flush();
        logic [7:0] v;
        if (mbits.size() > 0) begin
            v = 8'hFF;
            for (int i = 0; i < mbits.size(); i++) v[i[2:0]] = mbits[i];
            ea.push_back(exp_addr);
            ed.push_back(v);
            exp_addr = exp_addr + 25'd1;
            mbits.delete();
        end
    endtask

    task automatic half(input int len);
        repeat (len) @(negedge clk);
        cas_in = ~cas_in;
    endtask

    task automatic lead();
        @(negedge clk);
        cas_in = ~cas_in;
    endtask

    task automatic send_bit(input bit b, input bit mdl);
        if (b) repeat (4) half(int'($urandom_range(24, 16)));
        else   repeat (2) half(int'($urandom_range(50, 36)));
        if (mdl) model_bit(b);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit mdl);
        for (int i = 0; i < 8; i++) send_bit(b[i[2:0]], mdl);
    endtask

    task automatic wait_status(input string tag, input logic [2:0] s);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (status === s) break;
        end
        chk(tag, status, s);
    endtask

    task automatic wait_writes(input string tag, input int n);
        for (int i = 0; i < 1000; i++) begin
            if (wq_addr.size() >= n) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk(tag, wq_addr.size(), n);
    endtask

    task automatic wait_wr(input string tag);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (sdram_wr === 1'b1) break;
        end
        chk(tag, sdram_wr, 1'b1);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        chk({tag, "_count"}, wq_addr.size(), ea.size());
        n = (wq_addr.size() < ea.size()) ? wq_addr.size() : ea.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, wq_addr[i], ea[i]);
            chk({tag, "_data"}, wq_data[i], ed[i]);
        end
        wq_addr.delete();
        wq_data.delete();
        ea.delete();
        ed.delete();
    endtask

    initial begin : main
        logic [7:0] b0, b1;
        reset = 1'b1;
        en = 1'b0;
        cas_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_addr", sdram_addr, 25'd0);
        chk("rst_din", sdram_din, 8'd0);
        chk("rst_wr", sdram_wr, 1'b0);
        chk("rst_tape_end", tape_end, 25'd0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_status", status, 3'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_stays", status, 3'd0);

        // single byte 1,0,1,0,0,0,0,0
        en = 1'b1;
        model_reset();
        @(negedge clk);
        chk("arm_on_en", status, 3'd1);
        lead();
        send_byte(8'h05, 1'b1);
        wait_writes("byte_wait", 1);
        chk("byte_din_05", wq_data[0], 8'h05);
        chk("byte_tape_end", tape_end, 25'd1);
        compare_writes("byte");
        wait_status("byte_timeout_arm", 3'd1);

        // falling then rising enable restarts at address 0
        en = 1'b0;
        @(negedge clk);
        chk("fall_done", status, 3'd5);
        @(negedge clk);
        chk("done_idle", status, 3'd0);
        en = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rearm_addr", sdram_addr, 25'd0);

        // multi-byte with slow ack
        ack_delay = 5;
        lead();
        send_byte(8'hAA, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b1);
        wait_writes("multi_wait", 4);
        chk("multi_tape_end", tape_end, 25'd4);
        compare_writes("multi");
        wait_status("multi_arm", 3'd1);

        // flush on carrier loss: 0,1,1 then silence
        ack_delay = int'($urandom_range(3, 1));
        lead();
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        model_flush();
        wait_writes("flush_wait", 1);
        chk("flush_fe", wq_data[0], 8'hFE);
        compare_writes("flush");
        wait_status("flush_arm", 3'd1);
        chk("flush_addr_kept", sdram_addr, exp_addr);

        // glitch: 3 short then 2 long gives a single 0
        lead();
        repeat (3) half(20);
        repeat (2) half(44);
        model_bit(1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'($urandom), 1'b1);
        wait_writes("glitch_wait", 1);
        compare_writes("glitch");
        wait_status("glitch_arm", 3'd1);

        // falling enable with a partial byte
        lead();
        send_bit(1'($urandom), 1'b1);
        send_bit(1'($urandom), 1'b1);
        model_flush();
        repeat (20) @(negedge clk);
        en = 1'b0;
        wait_writes("fall_flush_wait", 1);
        compare_writes("fall_flush");
        wait_status("fall_flush_idle", 3'd0);

        // overrun: ack held across two byte-times
        en = 1'b1;
        model_reset();
        ack_hold = 1'b1;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        lead();
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("ovr_flag", overrun, 1'b1);
        chk("ovr_wr_held", sdram_wr, 1'b1);
        chk("ovr_din", sdram_din, b0);
        chk("ovr_addr", sdram_addr, 25'd0);
        ack_hold = 1'b0;
        wait_writes("ovr_wait", 1);
        compare_writes("ovr");
        wait_status("ovr_arm", 3'd1);
        chk("ovr_sticky", overrun, 1'b1);

        // full at the top address
        en = 1'b0;
        wait_status("full_pre_idle", 3'd0);
        en = 1'b1;
        model_reset();
        exp_addr = 25'h1FFFFFF;
        ack_hold = 1'b1;
        lead();
        send_byte(8'($urandom), 1'b1);
        wait_wr("full_wr");
        stab_en = 1'b0;
        force dut.r_addr = 25'h1FFFFFF;
        @(negedge clk);
        ack_hold = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sdram_wr !== 1'b1) break;
        end
        chk("full_flag", full, 1'b1);
        chk("full_done", status, 3'd5);
        release dut.r_addr;
        compare_writes("full");
        stab_en = 1'b1;

        // reset while a write is pending
        en = 1'b0;
        wait_status("rst_pre_idle", 3'd0);
        en = 1'b1;
        @(negedge clk);
        ack_hold = 1'b1;
        lead();
        send_byte(8'($urandom), 1'b0);
        wait_wr("rst_wr_pending");
        reset = 1'b1;
        en = 1'b0;
        @(negedge clk);
        chk("mid_rst_wr", sdram_wr, 1'b0);
        chk("mid_rst_addr", sdram_addr, 25'd0);
        chk("mid_rst_din", sdram_din, 8'd0);
        chk("mid_rst_tape_end", tape_end, 25'd0);
        chk("mid_rst_overrun", overrun, 1'b0);
        chk("mid_rst_full", full, 1'b0);
        chk("mid_rst_status", status, 3'd0);
        reset = 1'b0;
        ack_hold = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_rst_no_ack", wq_addr.size(), 0);
        en = 1'b1;
        @(negedge clk);
        chk("post_rst_arm", status, 3'd1);
        chk("post_rst_addr", sdram_addr, 25'd0);

        chk("stable_during_wr", unstable, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
